// File: rtl/wasm_fetch_ctrl.sv
// Bytecode fetch sequencer: reads opcode bytes and their LEB128 immediates from a
// registered ROM and hands complete instructions to the decoder over valid/ready.
module wasm_fetch_ctrl #(
    parameter int unsigned AW    = 4,
    parameter int unsigned EXTRA = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [AW:0]               i_start_pc,
    input  logic [AW:0]               i_code_lo,
    input  logic [AW:0]               i_code_hi,
    input  logic                      i_redirect,
    input  logic [AW:0]               i_redirect_pc,
    output logic [AW:0]               o_rom_addr,
    output logic [EXTRA-1:0]          o_rom_extra,
    output logic [AW:0]               o_rom_lower,
    output logic [AW:0]               o_rom_upper,
    input  logic [(2**EXTRA)*8-1:0]   i_rom_data,
    input  logic                      i_rom_error,
    output logic                      o_instr_valid,
    input  logic                      i_instr_ready,
    output logic [AW:0]               o_instr_pc,
    output logic [7:0]                o_instr_op,
    output logic [31:0]               o_instr_imm0,
    output logic [31:0]               o_instr_imm1,
    output logic [3:0]                o_instr_len,
    output logic                      o_busy,
    output logic                      o_fault,
    output logic [1:0]                o_fault_code
);
    localparam int unsigned DW = (2**EXTRA) * 8;
    localparam int unsigned EW = AW + 5;

    typedef enum logic [3:0] {
        StIdle, StOpReq, StOpDec, StImmReq, StImmDec, StImm2Req, StImm2Dec, StEmit, StFault
    } state_e;

    typedef enum logic [2:0] {ClsNone, ClsByte, ClsU32, ClsS32, ClsMem, ClsUnsup} cls_e;

    function automatic cls_e classify(input logic [7:0] op);
        cls_e c;
        case (op) inside
            8'h02, 8'h03, 8'h04, 8'h3F, 8'h40:        c = ClsByte;
            8'h0C, 8'h0D, 8'h10, [8'h20:8'h24]:       c = ClsU32;
            8'h41:                                    c = ClsS32;
            [8'h28:8'h3E]:                            c = ClsMem;
            8'h0E, 8'h11, 8'h42, 8'h44, 8'hFC, 8'hFD: c = ClsUnsup;
            default:                                  c = ClsNone;
        endcase
        return c;
    endfunction

    state_e      r_state, w_state_d;
    cls_e        r_cls, w_op_cls;
    logic [AW:0] r_pc, r_field_addr;
    logic [7:0]  r_op;
    logic [31:0] r_imm0, r_imm1;
    logic [3:0]  r_len;
    logic        r_fault;
    logic [1:0]  r_fault_code;

    logic [4:0][7:0] w_b;
    logic [2:0]      w_leb_len, w_flen;
    logic [31:0]     w_leb_u, w_leb_s, w_field_val;
    logic            w_is_byte, w_signed, w_bad5, w_out, w_busy, w_dec_fault;
    logic [1:0]      w_dec_code;
    logic [EW-1:0]   w_end;
    logic            w_unused_rom;

    assign w_unused_rom = ^i_rom_data[DW-1:40];
    assign w_op_cls     = classify(i_rom_data[7:0]);
    assign w_busy       = (r_state != StIdle) && (r_state != StFault);

    // LEB128 decode of the 5-byte window; rom[addr] sits in bits [39:32].
    always_comb begin
        for (int i = 0; i < 5; i++) w_b[i] = i_rom_data[39-8*i -: 8];
        w_leb_len = 3'd0;
        for (int i = 4; i >= 0; i--) if (!w_b[i][7]) w_leb_len = 3'(i + 1);
        w_leb_u = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(w_leb_len)) w_leb_u = w_leb_u | (32'(w_b[i][6:0]) << (7 * i));
        end
        w_leb_s = w_leb_u;
        case (w_leb_len)
            3'd1: if (w_leb_u[6])  w_leb_s = w_leb_u | 32'hFFFF_FF80;
            3'd2: if (w_leb_u[13]) w_leb_s = w_leb_u | 32'hFFFF_C000;
            3'd3: if (w_leb_u[20]) w_leb_s = w_leb_u | 32'hFFE0_0000;
            3'd4: if (w_leb_u[27]) w_leb_s = w_leb_u | 32'hF000_0000;
            default: ;
        endcase
        w_is_byte   = (r_state == StImmDec) && (r_cls == ClsByte);
        w_signed    = (r_state == StImmDec) && (r_cls == ClsS32);
        w_flen      = w_is_byte ? 3'd1 : w_leb_len;
        w_field_val = w_is_byte ? {24'd0, w_b[0]} : (w_signed ? w_leb_s : w_leb_u);
        w_bad5      = !w_is_byte && (w_leb_len == 3'd5) &&
                      (w_signed ? (w_b[4][6:4] != {3{w_b[4][3]}}) : (w_b[4][6:4] != 3'd0));
        // Widened so that pc wrap-around still reads as past code_hi.
        w_end       = EW'(r_pc) + EW'(r_len) + EW'(w_flen) - EW'(1);
        w_out       = w_end > EW'(i_code_hi);
    end

    always_comb begin
        w_dec_fault = 1'b0;
        w_dec_code  = 2'd0;
        case (r_state)
            StOpDec: begin
                if (i_rom_error) begin
                    w_dec_fault = 1'b1;
                    w_dec_code  = 2'd1;
                end else if (w_op_cls == ClsUnsup) begin
                    w_dec_fault = 1'b1;
                    w_dec_code  = 2'd3;
                end
            end
            StImmDec, StImm2Dec: begin
                if (!w_is_byte && (w_leb_len == 3'd0)) begin
                    w_dec_fault = 1'b1;
                    w_dec_code  = 2'd2;
                end else if (w_out) begin
                    w_dec_fault = 1'b1;
                    w_dec_code  = 2'd1;
                end else if (w_bad5) begin
                    w_dec_fault = 1'b1;
                    w_dec_code  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        if (i_start) begin
            w_state_d = StOpReq;
        end else if (i_redirect && w_busy) begin
            w_state_d = StOpReq;
        end else begin
            case (r_state)
                StOpReq:   w_state_d = StOpDec;
                StOpDec: begin
                    if (w_dec_fault)             w_state_d = StFault;
                    else if (w_op_cls == ClsNone) w_state_d = StEmit;
                    else                          w_state_d = StImmReq;
                end
                StImmReq:  w_state_d = StImmDec;
                StImmDec: begin
                    if (w_dec_fault)           w_state_d = StFault;
                    else if (r_cls == ClsMem)  w_state_d = StImm2Req;
                    else                       w_state_d = StEmit;
                end
                StImm2Req: w_state_d = StImm2Dec;
                StImm2Dec: w_state_d = w_dec_fault ? StFault : StEmit;
                StEmit:    if (i_instr_ready) w_state_d = StOpReq;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= '0;
            r_field_addr <= '0;
            r_cls        <= ClsNone;
            r_op         <= '0;
            r_imm0       <= '0;
            r_imm1       <= '0;
            r_len        <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
        end else if (i_start) begin
            r_pc         <= i_start_pc;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
        end else if (i_redirect && w_busy) begin
            r_pc <= i_redirect_pc;
        end else if (w_dec_fault) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_dec_code;
        end else begin
            case (r_state)
                StOpDec: begin
                    r_op         <= i_rom_data[7:0];
                    r_cls        <= w_op_cls;
                    r_imm0       <= '0;
                    r_imm1       <= '0;
                    r_len        <= 4'd1;
                    r_field_addr <= r_pc + 1'b1;
                end
                StImmDec, StImm2Dec: begin
                    if (r_state == StImmDec) r_imm0 <= w_field_val;
                    else                     r_imm1 <= w_field_val;
                    r_len        <= r_len + 4'(w_flen);
                    r_field_addr <= r_field_addr + (AW+1)'(w_flen);
                end
                StEmit: if (i_instr_ready) r_pc <= r_pc + (AW+1)'(r_len);
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rom_addr  = '0;
        o_rom_extra = '0;
        case (r_state)
            StOpReq: o_rom_addr = r_pc;
            StImmReq, StImm2Req: begin
                o_rom_addr  = r_field_addr;
                o_rom_extra = EXTRA'(4);
            end
            default: ;
        endcase
        o_instr_valid = (r_state == StEmit);
        o_busy        = w_busy;
    end

    assign o_rom_lower  = i_code_lo;
    assign o_rom_upper  = i_code_hi;
    assign o_instr_pc   = r_pc;
    assign o_instr_op   = r_op;
    assign o_instr_imm0 = r_imm0;
    assign o_instr_imm1 = r_imm1;
    assign o_instr_len  = r_len;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_wasm_fetch_ctrl.sv
// Scoreboard bench for wasm_fetch_ctrl: a registered ROM model answers fetches, a
// monitor checks each accepted instruction against queued expectations.
module tb_wasm_fetch_ctrl;
    logic         clk = 1'b0;
    logic         rst, start, redirect, ready;
    logic [4:0]   start_pc, redirect_pc, code_lo, code_hi;
    logic [4:0]   rom_addr, rom_lower, rom_upper, instr_pc;
    logic [3:0]   rom_extra, instr_len;
    logic [127:0] rom_data = '0;
    logic         rom_error = 1'b0;
    logic         instr_valid, busy, fault;
    logic [7:0]   instr_op;
    logic [31:0]  imm0, imm1;
    logic [1:0]   fault_code;

    typedef struct {
        logic [4:0]  pc;
        logic [7:0]  op;
        logic [31:0] imm0;
        logic [31:0] imm1;
        logic [3:0]  len;
    } exp_t;

    exp_t       sb[$];
    int         hs_cyc[$];
    int         hs_count = 0;
    int         cyc = 0;
    int         c0 = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] rom [32];

    wasm_fetch_ctrl #(.AW(4), .EXTRA(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_pc(start_pc),
        .i_code_lo(code_lo), .i_code_hi(code_hi), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_rom_addr(rom_addr), .o_rom_extra(rom_extra),
        .o_rom_lower(rom_lower), .o_rom_upper(rom_upper), .i_rom_data(rom_data),
        .i_rom_error(rom_error), .o_instr_valid(instr_valid), .i_instr_ready(ready),
        .o_instr_pc(instr_pc), .o_instr_op(instr_op), .o_instr_imm0(imm0),
        .o_instr_imm1(imm1), .o_instr_len(instr_len), .o_busy(busy), .o_fault(fault),
        .o_fault_code(fault_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: window right-justified, rom[addr] in the top used byte.
    always @(posedge clk) begin
        logic [127:0] d;
        logic         e;
        int           a;
        d = '0;
        e = 1'b0;
        for (int j = 0; j <= int'(rom_extra); j++) begin
            a = int'(rom_addr) + j;
            d[8*(int'(rom_extra)-j) +: 8] = rom[a % 32];
            if (a < int'(rom_lower) || a > int'(rom_upper)) e = 1'b1;
        end
        rom_data  <= d;
        rom_error <= e;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL timeout_%s: got no event, expected one within budget", name);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && ready) begin
            hs_cyc.push_back(cyc);
            hs_count++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_instr: got pc %0d op 0x%0h, expected none",
                         instr_pc, instr_op);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                chk("instr_op", 32'(instr_op), 32'(e.op));
                chk("instr_imm0", imm0, e.imm0);
                chk("instr_imm1", imm1, e.imm1);
                chk("instr_len", 32'(instr_len), 32'(e.len));
            end
        end
    end

    task automatic push(input logic [4:0] pc, input logic [7:0] op, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [3:0] len);
        sb.push_back('{pc, op, i0, i1, len});
    endtask

    task automatic load_prog1();
        logic [7:0] p [12];
        p = '{8'h41, 8'hC0, 8'hBB, 8'h78, 8'h20, 8'h05, 8'h28, 8'h02, 8'h80, 8'h01,
              8'h0B, 8'h11};
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < 12; i++) rom[i] = p[i];
    endtask

    task automatic do_start(input logic [4:0] pc);
        @(negedge clk);
        start    = 1'b1;
        start_pc = pc;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int i = 0; i < 80; i++) begin
            if (hs_count >= target) return;
            @(posedge clk);
            #1;
        end
        timeout(name);
    endtask

    task automatic wait_fault(input logic [1:0] code, input string name);
        for (int i = 0; i < 80; i++) begin
            if (fault) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_fault"}, 32'(fault), 32'd1);
        chk({name, "_code"}, 32'(fault_code), 32'(code));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; redirect = 1'b0; ready = 1'b1;
        start_pc = '0; redirect_pc = '0; code_lo = 5'd3; code_hi = 5'd12;
        load_prog1();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_lower", 32'(rom_lower), 32'd3);
        chk("rst_upper", 32'(rom_upper), 32'd12);
        rst = 1'b0; code_lo = 5'd0; code_hi = 5'd15;

        // Straight-line program with ready held high, then the 0x11 at pc11 faults.
        hs_cyc.delete();
        push(5'd0, 8'h41, 32'hFFFE_1DC0, 32'd0, 4'd4);
        push(5'd4, 8'h20, 32'd5, 32'd0, 4'd2);
        push(5'd6, 8'h28, 32'd2, 32'd128, 4'd4);
        push(5'd10, 8'h0B, 32'd0, 32'd0, 4'd1);
        do_start(5'd0);
        wait_hs(4, "prog1");
        if (hs_cyc.size() >= 4) begin
            chk("lat_s32", 32'(hs_cyc[0] - c0), 32'd4);
            chk("lat_u32", 32'(hs_cyc[1] - hs_cyc[0]), 32'd5);
            chk("lat_mem", 32'(hs_cyc[2] - hs_cyc[1]), 32'd7);
            chk("lat_none", 32'(hs_cyc[3] - hs_cyc[2]), 32'd3);
        end
        wait_fault(2'd3, "unsup");

        // Back-pressure on pc4.
        push(5'd0, 8'h41, 32'hFFFE_1DC0, 32'd0, 4'd4);
        push(5'd4, 8'h20, 32'd5, 32'd0, 4'd2);
        push(5'd6, 8'h28, 32'd2, 32'd128, 4'd4);
        push(5'd10, 8'h0B, 32'd0, 32'd0, 4'd1);
        do_start(5'd0);
        wait_hs(hs_count + 1, "stall_first");
        ready = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", 32'(instr_pc), 32'd4);
            chk("stall_op", 32'(instr_op), 32'h20);
            chk("stall_imm0", imm0, 32'd5);
            chk("stall_len", 32'(instr_len), 32'd2);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_next_addr", 32'(rom_addr), 32'd6);
        wait_hs(hs_count + 2, "stall_rest");
        wait_fault(2'd3, "stall_end");

        // Unterminated LEB, then restart clears the fault.
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h20;
        for (int i = 1; i < 6; i++) rom[i] = 8'h80;
        rom[12] = 8'h0B;
        rom[13] = 8'h11;
        do_start(5'd0);
        wait_fault(2'd2, "leb");
        push(5'd12, 8'h0B, 32'd0, 32'd0, 4'd1);
        do_start(5'd12);
        chk("restart_fault", 32'(fault), 32'd0);
        chk("restart_code", 32'(fault_code), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_hs(hs_count + 1, "restart");
        wait_fault(2'd3, "restart_end");

        // Start just past code_hi faults after OP_DEC.
        do_start(5'd16);
        @(posedge clk);
        #1;
        chk("oob_opdec_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        chk("oob_fault", 32'(fault), 32'd1);
        chk("oob_code", 32'(fault_code), 32'd1);

        // Immediate crossing code_hi, then one that just fits.
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[4] = 8'h20; rom[5] = 8'h85; rom[6] = 8'h01;
        code_hi = 5'd5;
        do_start(5'd4);
        wait_fault(2'd1, "imm_oob");
        code_hi = 5'd6;
        push(5'd4, 8'h20, 32'h85, 32'd0, 4'd3);
        do_start(5'd4);
        wait_hs(hs_count + 1, "imm_fit");
        wait_fault(2'd1, "imm_fit_end");

        // Redirect during IMM_DEC of pc0.
        code_hi = 5'd15;
        load_prog1();
        push(5'd10, 8'h0B, 32'd0, 32'd0, 4'd1);
        do_start(5'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        redirect = 1'b1;
        redirect_pc = 5'd10;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        chk("redirect_addr", 32'(rom_addr), 32'd10);
        wait_hs(hs_count + 1, "redirect");
        wait_fault(2'd3, "redirect_end");

        // Reset in IMM_REQ, then start and redirect together.
        do_start(5'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("immreq_addr", 32'(rom_addr), 32'd1);
        chk("immreq_extra", 32'(rom_extra), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_extra", 32'(rom_extra), 32'd0);
        chk("mid_rst_pc", 32'(instr_pc), 32'd0);
        chk("mid_rst_op", 32'(instr_op), 32'd0);
        chk("mid_rst_imm0", imm0, 32'd0);
        chk("mid_rst_len", 32'(instr_len), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        push(5'd4, 8'h20, 32'd5, 32'd0, 4'd2);
        push(5'd6, 8'h28, 32'd2, 32'd128, 4'd4);
        push(5'd10, 8'h0B, 32'd0, 32'd0, 4'd1);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd4; redirect = 1'b1; redirect_pc = 5'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        redirect = 1'b0;
        chk("prio_addr", 32'(rom_addr), 32'd4);
        wait_hs(hs_count + 3, "prio");
        wait_fault(2'd3, "prio_end");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wasm_fetch_ctrl.md
Name: wasm_fetch_ctrl

Overview:
Instruction-fetch sequencer for the WASM core's bytecode ROM (genrom-style: registered read, 1-cycle latency, variable-length window, bounds error). It walks the ROM from a start PC, fetches each opcode byte, then fetches and decodes its LEB128 immediates. It hands complete instructions to the decoder over a valid/ready handshake and supports PC redirect for branches and calls. Faults (bounds, malformed LEB, unsupported opcode) park the block until restarted.

Parameters:
AW, 4, ROM address parameter; every address port is AW+1 bits.
EXTRA, 4, ROM length-field width; the ROM data bus is 2**EXTRA*8 bits; must be >=3.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: load start_pc, clear fault, begin fetching
start_pc  in  AW+1  first instruction address
code_lo, code_hi  in  AW+1 each  legal code range, inclusive; driven to ROM bounds
redirect  in  1  one-cycle pulse: abandon current fetch, continue at redirect_pc
redirect_pc  in  AW+1  target address
rom_addr  out  AW+1  ROM address (combinational from state/pc)
rom_extra  out  EXTRA  window length minus 1
rom_lower, rom_upper  out  AW+1 each  copies of code_lo/code_hi
rom_data  in  2**EXTRA*8  ROM data; length-k+1 window right-justified, rom[addr] in the most significant used byte
rom_error  in  1  ROM out-of-range flag, aligned with rom_data
instr_valid  out  1  instruction available
instr_ready  in  1  decoder accepts
instr_pc, instr_op  out  AW+1, 8  opcode address and opcode byte
instr_imm0, instr_imm1  out  32 each  immediates, zero when unused
instr_len  out  4  total encoded bytes, 1..11
busy  out  1  state is neither IDLE nor FAULT
fault  out  1  sticky fault flag
fault_code  out  2  1 = bounds, 2 = malformed LEB, 3 = unsupported opcode

Behaviour:
- Reset: state IDLE, pc=0. All outputs 0 except rom_lower/rom_upper, which are always copies of code_lo/code_hi.
- States: IDLE, OP_REQ, OP_DEC, IMM_REQ, IMM_DEC, IMM2_REQ, IMM2_DEC, EMIT, FAULT.
- start is honoured in any state. It has priority over redirect: pc<=start_pc, fault/fault_code cleared, next state OP_REQ.
- OP_REQ: rom_addr=pc, rom_extra=0. Next state OP_DEC.
- OP_DEC: sample rom_data[7:0] and rom_error. If error, fault 1. Otherwise classify the opcode:
  - BYTE class (0x02,0x03,0x04,0x3F,0x40): imm0 = next byte.
  - U32 class (0x0C,0x0D,0x10,0x20-0x24): one unsigned LEB.
  - S32 class (0x41): one signed LEB.
  - MEM class (0x28-0x3E): unsigned align LEB, then unsigned offset LEB.
  - UNSUP (0x0E,0x11,0x42,0x44,0xFC,0xFD): fault 3.
  - All other opcodes: no immediate, go to EMIT.
- IMM_REQ and IMM2_REQ: rom_addr = address after the previous field, rom_extra=4 (5-byte window). The following *_DEC state decodes:
  - byte i = rom_data[39-8i -: 8]; len = first i with bit7==0, plus 1. No terminator in 5 bytes -> fault 2.
  - u32: value = OR of byte_i[6:0] << 7i. A 5th byte with bits[6:4] != 0 -> fault 2.
  - s32: sign-extend from bit 7*len-1 when len<5. A 5th byte with bits[6:4] != {3{bit3}} -> fault 2.
  - BYTE class uses only the first byte.
  - If pc+len_total-1 > code_hi -> fault 1, even when rom_error=0.
- EMIT: instr_valid=1; all instr_* fields stable until accepted. On instr_valid&&instr_ready: pc<=pc+instr_len, instr_valid drops next cycle, next state OP_REQ.
- Latency with ready held high, from OP_REQ to instr_valid: no immediate, 2 cycles; one immediate, 4 cycles; MEM, 6 cycles. Next OP_REQ follows the cycle after handshake.
- redirect in any busy state: pc<=redirect_pc, in-flight ROM data discarded, instr_valid=0 next cycle, next state OP_REQ. A redirect in the same cycle as an EMIT handshake still counts the instruction as accepted, and the pc advance is replaced by redirect_pc. redirect is ignored in IDLE and FAULT.
- FAULT: fault=1 and fault_code held; instr_valid=0; ROM idle (rom_addr=0, rom_extra=0). Exit only via start or rst.
- pc arithmetic is AW+1 bits and wraps. Wrap-around is caught by rom_error or the code_hi check.

Test Plan:
- ROM 0x41 C0 BB 78 | 20 05 | 28 02 80 01 | 0B; start_pc=0, range 0..15, ready=1 -> four instructions:
  - pc0: op 41, imm0=0xFFFE1DC0 (-123456), len4
  - pc4: op 20, imm0=5, len2
  - pc6: op 28, imm0=2, imm1=128, len4
  - pc10: op 0B, len1
  - Valid timing matches the latency rule.
- Hold ready=0 for 5 cycles on pc4 -> instr_* stable, pc unchanged; ready=1 -> pc6 fetched next.
- LEB 0x20 80 80 80 80 80 -> fault=1, fault_code=2, busy=0; then start pulse -> fault cleared, fetch restarts.
- Opcode 0x11 -> fault_code=3. start_pc=code_hi+1 -> fault_code=1 after OP_DEC. Immediate ends past code_hi -> fault_code=1.
- redirect to 10 during IMM_DEC of the pc0 instruction -> no instruction emitted for pc0, next instr_pc=10.
- rst asserted mid-IMM_REQ -> next cycle IDLE, all outputs 0; start and redirect both pulsed -> start_pc wins.
